// File: rtl/pattern_detect_prog.sv
// Programmable serial pattern detector: Mealy match, registered match_q, armed flag.
// Define PATTERN_DETECT_MATCH_COUNT_EN to build the saturating match counter and cnt_clr.
module pattern_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(3);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_r;
  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   fill;
  logic               overlap_r;
  logic               hit;
  logic               unused_bits;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  // Only the low len bits of the candidate window take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
  end

  assign window = {history[MAX_LEN-2:0], din};
  assign hit    = ((window ^ pattern_r) & len_mask) == '0;
  assign armed  = fill >= (len_r - LEN_ONE);
  assign match  = din_valid & ~cfg_we & armed & hit;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= MAX_LEN'(5);
      len_r     <= LEN_RST;
      overlap_r <= 1'b1;
      history   <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
    end else begin
      match_q <= match;
      if (cfg_we) begin
        pattern_r <= cfg_pattern;
        len_r     <= len_clamped;
        overlap_r <= cfg_overlap;
        history   <= '0;
        fill      <= '0;
      end else if (din_valid) begin
        history <= window;
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
        if (match && !overlap_r) begin
          fill <= '0;
        end else if (fill != LEN_MAX) begin
          fill <= fill + LEN_ONE;
        end
      end
    end
  end

`ifdef PATTERN_DETECT_MATCH_COUNT_EN
  logic [CNT_W-1:0] count_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (cnt_clr) begin
      count_r <= match ? CNT_W'(1) : '0;
    end else if (match && (count_r != '1)) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign match_count = count_r;
  assign unused_bits = history[MAX_LEN-1];
`else
  assign match_count = '0;
  assign unused_bits = history[MAX_LEN-1] ^ cnt_clr;
`endif

endmodule

// File: doc/pattern_detect_prog.md
PATTERN_DETECT_PROG -- requirements
Module: pattern_detect_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits (legal 2..16).
REQ-002 Parameter LEN_W, default 4, SHALL set the width of cfg_len; it SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of match_count.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 din  input  1  serial data bit.
REQ-007 din_valid  input  1  qualifies din; a bit is consumed only when this input is high.
REQ-008 cfg_we  input  1  loads cfg_pattern, cfg_len and cfg_overlap.
REQ-009 cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 is the last.
REQ-010 cfg_len  input  LEN_W  pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-012 cnt_clr  input  1  synchronous clear of match_count.
REQ-013 match  output  1  Mealy match, combinational from registered state and the current din/din_valid.
REQ-014 match_q  output  1  match registered, one cycle later.
REQ-015 armed  output  1  high when enough history is held for the next valid bit to complete a match.
REQ-016 match_count  output  CNT_W  number of matches.

Function
REQ-017 The block SHALL hold the registers: pattern, len, overlap, a MAX_LEN-bit history shift register (newest bit in the LSB), a fill counter (saturating at MAX_LEN), match_q and match_count.
REQ-018 On a cycle with cfg_we=1, the block SHALL load the configuration and clear history and fill; din on that cycle SHALL be ignored, and match SHALL be 0.
REQ-019 A cfg_len below 2 SHALL be stored as 2, and a cfg_len above MAX_LEN SHALL be stored as MAX_LEN.
REQ-020 The block SHALL assert match = din_valid & ~cfg_we & (fill >= len-1) & ({history[len-2:0], din} == pattern[len-1:0]).
REQ-021 On a consumed bit, history SHALL shift left with din entering bit 0, and fill SHALL increment (saturating).
REQ-022 On a match with overlap=1, fill SHALL continue normally; on a match with overlap=0, fill SHALL be set to 0, so a new match needs len fresh bits.
REQ-023 When din_valid=0, history, fill and match_count SHALL hold, and match SHALL be 0.
REQ-024 match_q SHALL equal the previous cycle's match (latency 1).
REQ-025 The block SHALL drive armed = (fill >= len-1).
REQ-026 When MATCH_COUNT_EN is defined, match_count SHALL increment on each match and saturate at all-ones without wrapping.
REQ-027 When MATCH_COUNT_EN is defined and cnt_clr and match occur on the same cycle, match_count SHALL become 1.
REQ-028 When MATCH_COUNT_EN is defined and cnt_clr occurs alone, match_count SHALL become 0.
REQ-029 Configuration changes SHALL NOT affect match_count.

Reset
REQ-030 While rst_n=0, the block SHALL hold pattern=0b101, len=3, overlap=1, history=0, fill=0, match_q=0 and match_count=0.
REQ-031 While rst_n=0, match and armed SHALL read 0.
REQ-032 Reset asserted mid-pattern SHALL discard all partial history; after release, a match SHALL need len fresh bits.
REQ-033 The reset configuration SHALL make the block detect overlapping "101" with no cfg_we, so it behaves as a drop-in 101 detector.

Configuration
REQ-034 Macro PATTERN_DETECT_MATCH_COUNT_EN SHALL control the match counter.
REQ-035 When PATTERN_DETECT_MATCH_COUNT_EN is defined, the block SHALL implement match_count and cnt_clr as specified in REQ-026 to REQ-029.
REQ-036 When PATTERN_DETECT_MATCH_COUNT_EN is undefined, match_count SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-037 Scenario: reset, then din_valid=1 with stream 1,0,1,0,1 -> match high on bits 3 and 5; match_q high one cycle after each; count=2.
REQ-038 Scenario: cfg 1101, len 4, overlap 0, stream 1,1,0,1,1,0,1 -> single match on bit 4; bit 7 gives no match; count=1.
REQ-039 Scenario: same stream with overlap 1 -> matches on bits 4 and 7; count=2.
REQ-040 Scenario: stream 1,0 then din_valid=0 for 5 cycles then 1 -> match on the final bit; no match during the gap; armed high throughout the gap.
REQ-041 Scenario: cfg_len=0 -> behaves as len 2.
REQ-042 Scenario: cfg_len=15 with MAX_LEN=8 -> behaves as len 8; the pattern of 8 ones matches on the 8th consecutive one.
REQ-043 Scenario: CNT_W=2, seven matches -> count saturates at 3; cnt_clr together with a match -> count=1; rst_n low mid-pattern 1,0 then 1 -> no match.
